// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package loader_pkg;

  localparam int LOADER_ADX_W = 7;
  localparam int LOADER_DEPTH = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSEMBLE = 3'd1,
    WRITE    = 3'd2,
    CHECK    = 3'd3,
    FINISH   = 3'd4
  } loaderState_t;

  // Requested word count limited to the memory depth.
  function automatic logic [8:0] clampCount(input logic [7:0] n, input int depth);
    logic [8:0] d;
    d = 9'(depth);
    return ({1'b0, n} > d) ? d : {1'b0, n};
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordValid
);

  logic [23:0] shiftReg;
  logic [1:0]  idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      idx      <= '0;
    end else if (clr) begin
      shiftReg <= '0;
      idx      <= '0;
    end else if (shiftEn) begin
      shiftReg <= {shiftReg[15:0], byteIn};
      idx      <= idx + 2'd1;
    end
  end

  // The fourth byte completes the word combinationally so the FSM can latch it on the same edge.
  assign word      = {shiftReg, byteIn};
  assign wordValid = shiftEn && (idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams bytes into 32-bit instruction words and writes them to instruction memory.
// Optional checksum byte after the last word is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADX_W = LOADER_ADX_W,
  parameter int DEPTH = LOADER_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             IMR,
  output logic [31:0]      instr2load,
  output logic [ADX_W-1:0] loadAdx,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  loaderState_t state;
  logic [8:0]   count;
  logic [8:0]   wordCnt;
  logic [8:0]   reqCount;
  logic         accept;
  logic         packEn;
  logic         packClr;
  logic         wordValid;
  logic [31:0]  packWord;
  logic         lastWord;

  assign reqCount = clampCount(num_words, DEPTH);
  assign accept   = byte_valid && byte_ready;
  assign packEn   = accept && (state == ASSEMBLE);
  assign packClr  = (state == IDLE) && start;
  assign lastWord = ((wordCnt + 9'd1) == count);

  byte_packer uPacker (
    .clk       (clk),
    .rst       (rst),
    .clr       (packClr),
    .shiftEn   (packEn),
    .byteIn    (byte_data),
    .word      (packWord),
    .wordValid (wordValid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] chk;
  assign chk = sum + byte_data;
`else
  assign err = 1'b0;
`endif

  // Outputs are registered alongside the state, so they always reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      wordCnt    <= '0;
      byte_ready <= 1'b0;
      IMR        <= 1'b0;
      instr2load <= '0;
      loadAdx    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
      err        <= 1'b0;
`endif
    end else begin
      IMR  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count    <= reqCount;
            wordCnt  <= '0;
            loadAdx  <= '0;
            cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum      <= '0;
            err      <= 1'b0;
`endif
            if (reqCount == 9'd0) begin
              state <= FINISH;
            end else begin
              state      <= ASSEMBLE;
              byte_ready <= 1'b1;
            end
          end
        end
        ASSEMBLE: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) sum <= chk;
`endif
          if (wordValid) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            IMR        <= 1'b1;
            instr2load <= packWord;
          end
        end
        WRITE: begin
          wordCnt <= wordCnt + 9'd1;
          if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= CHECK;
            byte_ready <= 1'b1;
`else
            state      <= FINISH;
`endif
          end else begin
            // Address stops on the last word so it never wraps past DEPTH-1.
            loadAdx    <= loadAdx + ADX_W'(1);
            state      <= ASSEMBLE;
            byte_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (chk != 8'd0) err <= 1'b1;
            state      <= FINISH;
            byte_ready <= 1'b0;
          end
        end
`endif
        FINISH: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write-queue scoreboard checked every cycle.
module tb_program_loader;

  localparam int ADX_W = 7;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       num_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             IMR;
  logic [31:0]      instr2load;
  logic [ADX_W-1:0] loadAdx;
  logic             cpu_hold;
  logic             done;
  logic             err;

  program_loader #(.ADX_W(ADX_W), .DEPTH(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .IMR        (IMR),
    .instr2load (instr2load),
    .loadAdx    (loadAdx),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int          adx;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          nChecks = 0;
  int          nFail   = 0;
  int          imrCount = 0;
  int          lastAdx = -1;
  logic [31:0] lastData = '0;
  logic        prevImr = 1'b0;
  logic        prevHold = 1'b0;
  logic [7:0]  sumModel = '0;
  logic [31:0] wordMem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every IMR pulse must match the oldest pending expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (IMR) begin
        check("imr_one_cycle", {31'd0, prevImr}, 32'd0);
        check("imr_expected", (expQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (expQ.size() > 0) begin
          check("write_adx", 32'(loadAdx), 32'(expQ[0].adx));
          check("write_data", instr2load, expQ[0].data);
          void'(expQ.pop_front());
        end
        imrCount++;
        lastAdx  = int'(loadAdx);
        lastData = instr2load;
      end
      if (done) begin
        check("hold_falls_with_done", {31'd0, cpu_hold}, 32'd0);
        check("hold_before_done", {31'd0, prevHold}, 32'd1);
      end
      if (byte_ready) check("ready_implies_hold", {31'd0, cpu_hold}, 32'd1);
`ifndef LOADER_CHECKSUM_EN
      check("err_tied_low", {31'd0, err}, 32'd0);
`endif
    end
    prevImr  = IMR;
    prevHold = cpu_hold;
  end

  task automatic doStart(input int n);
    @(posedge clk); #1;
    num_words = 8'(n);
    start     = 1'b1;
    sumModel  = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 200) begin
        check("byte_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] v;
      v = w[31 - 8*b -: 8];
      sumModel = sumModel + v;
      sendByte(v, gap);
    end
  endtask

  task automatic sendChecksum(input logic [7:0] adj);
    logic [7:0] c;
    c = (8'd0 - sumModel) + adj;
`ifdef LOADER_CHECKSUM_EN
    sendByte(c, 1'b0);
`endif
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Full session driven from wordMem; the model queues one write per clamped word.
  task automatic loadSession(input int n, input bit gap);
    int cnt;
    cnt = (n > 128) ? 128 : n;
    for (int i = 0; i < cnt; i++) expQ.push_back('{adx: i, data: wordMem[i]});
    doStart(n);
    for (int i = 0; i < cnt; i++) sendWord(wordMem[i], gap);
    sendChecksum(8'd0);
    waitDone(2000);
    check("writes_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    #2;
    check("rst_imr", {31'd0, IMR}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_instr", instr2load, 32'd0);
    check("rst_adx", 32'(loadAdx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-word load
    wordMem[0] = 32'h12345678; wordMem[1] = 32'hAABBCCDD;
    base = imrCount;
    loadSession(2, 1'b0);
    check("two_word_count", 32'(imrCount - base), 32'd2);
    check("two_word_last_adx", 32'(lastAdx), 32'd1);
    check("two_word_last_data", lastData, 32'hAABBCCDD);

    // Zero-word load: done two edges after start, no writes
    base = imrCount;
    @(posedge clk); #1;
    num_words = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done_early", {31'd0, done}, 32'd0);
    check("zero_hold_early", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_hold_after", {31'd0, cpu_hold}, 32'd0);
    check("zero_no_imr", 32'(imrCount - base), 32'd0);

    // Gappy byte_valid, one word
    wordMem[0] = 32'hDEADBEEF;
    base = imrCount;
    loadSession(1, 1'b1);
    check("gap_count", 32'(imrCount - base), 32'd1);
    check("gap_data", lastData, 32'hDEADBEEF);

    // start while busy must be ignored
    base = imrCount;
    expQ.push_back('{adx: 0, data: 32'hCAFEF00D});
    doStart(1);
    num_words = 8'd5; start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b0;
    sendWord(32'hCAFEF00D, 1'b0);
    sendChecksum(8'd0);
    waitDone(200);
    check("busy_start_count", 32'(imrCount - base), 32'd1);
    check("busy_start_drained", 32'(expQ.size()), 32'd0);

    // Clamp: 200 requested, 128 written
    for (int i = 0; i < 128; i++) wordMem[i] = {8'(i), 8'(~i), 8'(i * 3), 8'hC3};
    base = imrCount;
    loadSession(200, 1'b0);
    check("clamp_count", 32'(imrCount - base), 32'd128);
    check("clamp_last_adx", 32'(lastAdx), 32'd127);
    check("clamp_adx_hold", 32'(loadAdx), 32'd127);

    // Reset mid-word
    base = imrCount;
    doStart(1);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_hold", {31'd0, cpu_hold}, 32'd0);
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_instr", instr2load, 32'd0);
    check("midrst_adx", 32'(loadAdx), 32'd0);
    check("midrst_imr", {31'd0, IMR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    check("midrst_no_imr", 32'(imrCount - base), 32'd0);
    wordMem[0] = 32'h00000001;
    loadSession(1, 1'b0);
    check("restart_adx", 32'(lastAdx), 32'd0);
    check("restart_data", lastData, 32'h00000001);

`ifdef LOADER_CHECKSUM_EN
    // Literal checksum bytes: 01+02+03+04 = 0A, so F6 is good and F7 is bad
    expQ.push_back('{adx: 0, data: 32'h01020304});
    doStart(1);
    sendWord(32'h01020304, 1'b0);
    sendByte(8'hF6, 1'b0);
    waitDone(200);
    check("chk_good_err", {31'd0, err}, 32'd0);
    expQ.push_back('{adx: 0, data: 32'h01020304});
    doStart(1);
    sendWord(32'h01020304, 1'b0);
    sendByte(8'hF7, 1'b0);
    waitDone(200);
    check("chk_bad_err", {31'd0, err}, 32'd1);
    repeat (4) @(negedge clk);
    check("chk_err_sticky", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    num_words = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("chk_err_cleared", {31'd0, err}, 32'd0);
    waitDone(20);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
